decode_stage: RTL and testbench

- RV32I instruction-decode stage for the audio SoC core; sits between fetch and execute.
- Drives the register file read addresses and consumes its asynchronous read data.
- Applies EX/WB operand bypass, detects load-use hazards and registers a decoded bundle into the ID/EX pipeline register.
- Uses valid/ready handshakes on both sides.

---
 rtl/core_pkg.sv | 51 +++++
 rtl/imm_gen.sv | 36 +++
 rtl/decode_stage.sv | 142 ++++++++++++++
 tb/tb_decode_stage.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions for the core pipeline: op classes and RV32I opcodes.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package core_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [3:0] {
        OP_LUI     = 4'd0,
        OP_AUIPC   = 4'd1,
        OP_JAL     = 4'd2,
        OP_JALR    = 4'd3,
        OP_BRANCH  = 4'd4,
        OP_LOAD    = 4'd5,
        OP_STORE   = 4'd6,
        OP_IMM     = 4'd7,
        OP_REG     = 4'd8,
        OP_SYSTEM  = 4'd9,
        OP_ILLEGAL = 4'd15
    } op_class_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Every opcode constant ends in 2'b11, so a full 7-bit match also
    // rejects compressed/invalid encodings with instr[1:0] != 2'b11.
    function automatic op_class_e classify(input logic [31:0] instr);
        case (instr[6:0])
            OPC_LUI:    return OP_LUI;
            OPC_AUIPC:  return OP_AUIPC;
            OPC_JAL:    return OP_JAL;
            OPC_JALR:   return OP_JALR;
            OPC_BRANCH: return OP_BRANCH;
            OPC_LOAD:   return OP_LOAD;
            OPC_STORE:  return OP_STORE;
            OPC_OP_IMM: return OP_IMM;
            OPC_OP:     return OP_REG;
            OPC_SYSTEM: return OP_SYSTEM;
            default:    return OP_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: selects the RV32I format from the opcode and sign-extends to XLEN.
// Latency: combinational.
// Backpressure: none (pure function of instr).
// Ports: instr (32-bit instruction word) -> imm (XLEN immediate; 0 for R-type/illegal).
module imm_gen
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (instr[6:0])
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:
                imm32 = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm32 = {instr[31:12], 12'b0};
            OPC_JAL:
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: reads the register file, bypasses EX/WB results, detects load-use hazards.
// Latency: one cycle from if handshake to id_valid.
// Backpressure: ID/EX register holds while id_valid & !id_ready; if_ready drops on stall, hazard or flush.
// Ports: if_* fetch side, rf_* register file read port, ex_*/wb_* bypass sources,
//        flush squash, id_* registered ID/EX bundle.
module decode_stage
    import core_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter bit EX_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [XLEN-1:0] ex_result,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [3:0]      id_op,
    output logic [3:0]      id_funct,
    output logic [4:0]      id_rd,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic            id_illegal
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        op_class_e       op;
        logic [3:0]      funct;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } id_bundle_t;

    op_class_e       cls;
    logic            illegal;
    logic            rs1_used;
    logic            rs2_used;
    logic            rd_written;
    logic            ex_fwd_ok;
    logic            hz;
    logic            adv;
    logic [XLEN-1:0] imm;
    id_bundle_t      dec;
    id_bundle_t      bundle_d, bundle_q;
    logic            valid_d, valid_q;

    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (if_instr),
        .imm   (imm)
    );

    // A load in EX has no result yet, so it is never a forwarding source.
    assign ex_fwd_ok = ex_valid & ex_we & ~ex_is_load & EX_BYPASS;

    // x0 first, then EX (youngest), then WB (RF write not visible until next edge).
    function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf_val);
        if (rs == 5'd0)                    return '0;
        else if (ex_fwd_ok && ex_rd == rs) return ex_result;
        else if (wb_we && wb_rd == rs)     return wb_wd;
        else                               return rf_val;
    endfunction

    always_comb begin
        cls        = classify(if_instr);
        illegal    = (cls == OP_ILLEGAL);
        rs1_used   = !illegal && !(cls inside {OP_LUI, OP_AUIPC, OP_JAL});
        rs2_used   = (cls inside {OP_REG, OP_STORE, OP_BRANCH});
        rd_written = !illegal && !(cls inside {OP_BRANCH, OP_STORE, OP_SYSTEM});

        dec.pc      = if_pc;
        dec.op      = cls;
        dec.funct   = {if_instr[30], if_instr[14:12]};
        dec.rd      = rd_written ? if_instr[11:7] : 5'd0;
        dec.rs1_val = resolve(rf_rs1, rf_rd1);
        dec.rs2_val = resolve(rf_rs2, rf_rd2);
        dec.imm     = imm;
        dec.illegal = illegal;
    end

    // Without EX bypass every EX RAW stalls; with it only loads do.
    assign hz = if_valid & ex_valid & ex_we & (ex_rd != 5'd0)
              & ((rs1_used & (ex_rd == rf_rs1)) | (rs2_used & (ex_rd == rf_rs2)))
              & (ex_is_load | ~EX_BYPASS);

    assign adv      = ~valid_q | id_ready;
    assign if_ready = adv & ~hz & ~flush;

    always_comb begin
        valid_d  = valid_q;
        bundle_d = bundle_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (adv) begin
            valid_d  = if_valid & ~hz;
            bundle_d = dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else begin
            valid_q  <= valid_d;
            bundle_q <= bundle_d;
        end
    end

    assign id_valid   = valid_q;
    assign id_pc      = bundle_q.pc;
    assign id_op      = bundle_q.op;
    assign id_funct   = bundle_q.funct;
    assign id_rd      = bundle_q.rd;
    assign id_rs1_val = bundle_q.rs1_val;
    assign id_rs2_val = bundle_q.rs2_val;
    assign id_imm     = bundle_q.imm;
    assign id_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import core_pkg::*;

    localparam bit BYP = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 0, if_ready;
    logic [31:0] if_instr = 0, if_pc = 0;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rd1 = 0, rf_rd2 = 0;
    logic        ex_valid = 0, ex_we = 0, ex_is_load = 0;
    logic [4:0]  ex_rd = 0;
    logic [31:0] ex_result = 0;
    logic        wb_we = 0;
    logic [4:0]  wb_rd = 0;
    logic [31:0] wb_wd = 0;
    logic        flush = 0;
    logic        id_valid, id_ready = 0;
    logic [31:0] id_pc, id_rs1_val, id_rs2_val, id_imm;
    logic [3:0]  id_op, id_funct;
    logic [4:0]  id_rd;
    logic        id_illegal;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .EX_BYPASS(BYP)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_result(ex_result),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_op(id_op),
        .id_funct(id_funct), .id_rd(id_rd), .id_rs1_val(id_rs1_val),
        .id_rs2_val(id_rs2_val), .id_imm(id_imm), .id_illegal(id_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  op;
        logic [3:0]  funct;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    logic [31:0] regs [32];
    logic        m_valid = 1'b0;
    exp_t        m_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [4:0] rs, input logic [31:0] rf);
        if (rs == 0) return 32'd0;
        if (ex_valid && ex_we && !ex_is_load && ex_rd == rs && BYP) return ex_result;
        if (wb_we && wb_rd == rs) return wb_wd;
        return rf;
    endfunction

    function automatic logic [3:0] ref_class(input logic [31:0] i);
        if (i[1:0] != 2'b11) return 4'd15;
        case (i[6:2])
            5'b01101: return OP_LUI;
            5'b00101: return OP_AUIPC;
            5'b11011: return OP_JAL;
            5'b11001: return OP_JALR;
            5'b11000: return OP_BRANCH;
            5'b00000: return OP_LOAD;
            5'b01000: return OP_STORE;
            5'b00100: return OP_IMM;
            5'b01100: return OP_REG;
            5'b11100: return OP_SYSTEM;
            default:  return 4'd15;
        endcase
    endfunction

    // Immediates built arithmetically from the field weights of each format.
    function automatic logic [31:0] ref_imm(input logic [31:0] i, input logic [3:0] c);
        int s;
        s = 0;
        case (c)
            OP_JALR, OP_LOAD, OP_IMM, OP_SYSTEM:
                s = (i[31] ? -2048 : 0) + int'(i[30:20]);
            OP_STORE:
                s = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
            OP_BRANCH:
                s = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            OP_JAL:
                s = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                  + int'(i[30:21]) * 2;
            OP_LUI, OP_AUIPC:
                s = int'(i & 32'hFFFF_F000);
            default: s = 0;
        endcase
        return 32'(s);
    endfunction

    function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        exp_t e;
        logic [3:0] c;
        c = ref_class(i);
        e.pc    = pc;
        e.op    = c;
        e.funct = {i[30], i[14:12]};
        e.ill   = (c == 4'd15);
        e.rd    = (e.ill || c == OP_BRANCH || c == OP_STORE || c == OP_SYSTEM) ? 5'd0 : i[11:7];
        e.a     = ref_operand(i[19:15], regs[i[19:15]]);
        e.b     = ref_operand(i[24:20], regs[i[24:20]]);
        e.imm   = ref_imm(i, c);
        return e;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] i);
        logic [3:0] c;
        bit u1, u2;
        c  = ref_class(i);
        u1 = (c != 4'd15) && c != OP_LUI && c != OP_AUIPC && c != OP_JAL;
        u2 = (c == OP_REG) || (c == OP_STORE) || (c == OP_BRANCH);
        return if_valid && ex_valid && ex_we && ex_rd != 0
            && ((u1 && ex_rd == i[19:15]) || (u2 && ex_rd == i[24:20]))
            && (ex_is_load || !BYP);
    endfunction

    // One clock: called at posedge+1 with inputs already driven.
    task automatic step();
        exp_t d;
        bit   hz, adv;
        rf_rd1 = regs[if_instr[19:15]];
        rf_rd2 = regs[if_instr[24:20]];
        d   = ref_decode(if_instr, if_pc);
        hz  = ref_hazard(if_instr);
        adv = !m_valid || id_ready;
        #1;
        chk("if_ready", {31'd0, if_ready}, {31'd0, adv && !hz && !flush});
        chk("rf_rs1", {27'd0, rf_rs1}, {27'd0, if_instr[19:15]});
        chk("rf_rs2", {27'd0, rf_rs2}, {27'd0, if_instr[24:20]});
        if (flush) m_valid = 1'b0;
        else if (adv) begin
            m_valid = if_valid && !hz;
            if (m_valid) m_b = d;
        end
        @(posedge clk);
        if (wb_we && wb_rd != 0) regs[wb_rd] = wb_wd;
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("id_pc", id_pc, m_b.pc);
            chk("id_op", {28'd0, id_op}, {28'd0, m_b.op});
            chk("id_funct", {28'd0, id_funct}, {28'd0, m_b.funct});
            chk("id_rd", {27'd0, id_rd}, {27'd0, m_b.rd});
            chk("id_rs1_val", id_rs1_val, m_b.a);
            chk("id_rs2_val", id_rs2_val, m_b.b);
            chk("id_imm", id_imm, m_b.imm);
            chk("id_illegal", {31'd0, id_illegal}, {31'd0, m_b.ill});
        end
    endtask

    task automatic clear_side();
        ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        wb_we = 0; wb_rd = 0; wb_wd = 0; flush = 0;
    endtask

    logic [6:0] opc_tab [11];

    initial begin
        opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                    7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011, 7'b1111111};
        for (int r = 0; r < 32; r++) regs[r] = $urandom;

        // Reset state
        #2;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'd0);
        chk("rst_id_imm", id_imm, 32'd0);
        chk("rst_id_rs1_val", id_rs1_val, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // addi x5,x0,-3
        if_valid = 1; id_ready = 1; if_instr = 32'hFFD00293; if_pc = 32'h100;
        step();
        chk("addi_op", {28'd0, id_op}, {28'd0, OP_IMM});
        chk("addi_rd", {27'd0, id_rd}, 32'd5);
        chk("addi_imm", id_imm, 32'hFFFF_FFFD);
        chk("addi_rs1", id_rs1_val, 32'd0);

        // EX bypass: add x8,x7,x7
        ex_valid = 1; ex_we = 1; ex_rd = 7; ex_result = 32'h1234;
        if_instr = 32'h00738433; if_pc = 32'h104;
        step();
        chk("exbyp_rs1", id_rs1_val, 32'h1234);
        chk("exbyp_rs2", id_rs2_val, 32'h1234);
        clear_side();

        // WB bypass with a stale register file: addi x4,x3,0
        regs[3] = 32'd0;
        wb_we = 1; wb_rd = 3; wb_wd = 32'hA5A5A5A5;
        if_instr = 32'h00018213; if_pc = 32'h108;
        step();
        chk("wbbyp_rs1", id_rs1_val, 32'hA5A5A5A5);
        clear_side();

        // Load-use: sw x10,0(x2) behind a load to x10
        ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 10;
        if_instr = 32'h00A12023; if_pc = 32'h10C;
        step();
        chk("lu_bubble", {31'd0, id_valid}, 32'd0);
        clear_side();
        step();
        chk("lu_issue", {31'd0, id_valid}, 32'd1);

        // Backpressure for 3 cycles, then flush while still stalled
        if_instr = 32'h00128313; if_pc = 32'h110;
        step();
        id_ready = 0; if_instr = 32'h00A00093; if_pc = 32'h114;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_pc_stable", id_pc, 32'h110);
        end
        flush = 1;
        step();
        flush = 0; id_ready = 1;

        // x0 never bypassed from WB: add x1,x0,x0
        wb_we = 1; wb_rd = 0; wb_wd = 32'hFFFF;
        if_instr = 32'h000000B3; if_pc = 32'h118;
        step();
        chk("x0_rs1", id_rs1_val, 32'd0);
        clear_side();

        // Illegal opcode
        if_instr = 32'h0000007F; if_pc = 32'h11C;
        step();
        chk("ill_flag", {31'd0, id_illegal}, 32'd1);
        chk("ill_rd", {27'd0, id_rd}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            ins[6:0]   = opc_tab[$urandom_range(0, 10)];
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if_instr   = ins;
            if_pc      = $urandom;
            if_valid   = ($urandom_range(0, 3) != 0);
            id_ready   = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            ex_valid   = ($urandom_range(0, 1) == 1) && (ins[6:0] != 7'b1111111);
            ex_we      = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_result  = $urandom;
            wb_we      = ($urandom_range(0, 1) == 1);
            wb_rd      = 5'($urandom_range(0, 7));
            wb_wd      = $urandom;
            if (n == 300) begin
                rst = 1'b1;
                #1;
                chk("async_rst_valid", {31'd0, id_valid}, 32'd0);
                chk("async_rst_rd", {27'd0, id_rd}, 32'd0);
                m_valid = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
